// File: rtl/manchester_frame_rx_pkg.sv
// Shared definitions for the Manchester frame receiver: FSM state encoding
// and the fixed preamble that opens every frame.
package manchester_frame_rx_pkg;

  typedef enum logic [1:0] {
    ST_HUNT     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2
  } state_e;

  localparam logic [3:0] PREAMBLE     = 4'b1010;
  localparam int         PREAMBLE_LEN = 4;

endpackage

// File: rtl/manchester_edge_sync.sv
// Brings the asynchronous Manchester line into the clk domain and produces
// registered one-cycle rise/fall strobes for the receiver FSM.
module manchester_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx_i,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q, sync2_q, prev_q, rise_q, fall_q;

  // Two-flop synchroniser, registered copy of the level and edge strobes.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every flop sample the pre-edge value,
    // so the stages form a true pipeline regardless of statement order.
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= sync2_q & ~prev_q;
      fall_q  <= ~sync2_q & prev_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/manchester_frame_rx.sv
// Manchester frame receiver: locks on the preamble's first mid-bit edge,
// tracks bit timing from mid-bit transitions, checks the 1010 preamble and
// assembles LENGTH payload bits (MSB first) into data_out_o.
module manchester_frame_rx
  import manchester_frame_rx_pkg::*;
#(
  parameter int LENGTH     = 20,
  parameter int OVERSAMPLE = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_in_i,
  output logic [LENGTH-1:0] data_out_o,
  output logic              data_valid_o,
  output logic              frame_error_o,
  output logic              busy_o
);

  localparam int CW  = $clog2(2 * OVERSAMPLE + 1);
  localparam int BCW = $clog2(LENGTH + 1);

  localparam logic [CW-1:0]  SAT_C     = CW'(2 * OVERSAMPLE);
  localparam logic [CW-1:0]  EARLY_C   = CW'((3 * OVERSAMPLE) / 4);
  localparam logic [CW-1:0]  LATE_C    = CW'((5 * OVERSAMPLE) / 4);
  localparam logic [BCW-1:0] LAST_PRE  = BCW'(PREAMBLE_LEN - 1);
  localparam logic [BCW-1:0] LAST_DATA = BCW'(LENGTH - 1);

  logic rise, fall, edge_any, mid_edge;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [LENGTH-2:0] shift_q, shift_d;
  logic [LENGTH-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              frame_error_q, frame_error_d;
  logic [1:0]        pre_idx;

  manchester_edge_sync u_edge_sync (
    .clk    (clk),
    .reset  (reset),
    .rx_i   (rx_in_i),
    .rise_o (rise),
    .fall_o (fall)
  );

  // The run counter (HUNT) and phase counter (PREAMBLE/DATA) share one
  // saturating register; cnt_inc is the elapsed cycle count seen this cycle.
  assign cnt_inc  = (cnt_q == SAT_C) ? SAT_C : cnt_q + CW'(1);
  assign edge_any = rise | fall;
  assign mid_edge = edge_any && (cnt_inc >= EARLY_C) && (cnt_inc <= LATE_C);
  assign pre_idx  = 2'(PREAMBLE_LEN - 1) - bit_cnt_q[1:0];

  // Next-state logic: lock, bit-timing windows, preamble check, payload shift.
  always_comb begin
    // NOTE: every target gets a default first so no path can leave it
    // unassigned and infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_inc;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    frame_error_d = 1'b0;

    unique case (state_q)
      ST_HUNT: begin
        if (edge_any) begin
          cnt_d = '0;
          // A long low run ended by a rise is the first preamble mid-bit.
          if (rise && cnt_inc >= EARLY_C) begin
            state_d   = ST_PREAMBLE;
            bit_cnt_d = BCW'(1);
          end
        end
      end
      ST_PREAMBLE, ST_DATA: begin
        if (mid_edge) begin
          cnt_d = '0;
          if (state_q == ST_PREAMBLE) begin
            if (rise != PREAMBLE[pre_idx]) begin
              frame_error_d = 1'b1;
              state_d       = ST_HUNT;
              bit_cnt_d     = '0;
            end else if (bit_cnt_q == LAST_PRE) begin
              state_d   = ST_DATA;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + BCW'(1);
            end
          end else begin
            shift_d = {shift_q[LENGTH-3:0], rise};
            if (bit_cnt_q == LAST_DATA) begin
              data_out_d   = {shift_q, rise};
              data_valid_d = 1'b1;
              state_d      = ST_HUNT;
              bit_cnt_d    = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + BCW'(1);
            end
          end
        end else if (cnt_inc > LATE_C) begin
          // No mid-bit transition inside the window: timing is lost.
          frame_error_d = 1'b1;
          state_d       = ST_HUNT;
          cnt_d         = '0;
          bit_cnt_d     = '0;
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  // State, counters, shift register and registered output pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_HUNT;
      cnt_q         <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign data_out_o    = data_out_q;
  assign data_valid_o  = data_valid_q;
  assign frame_error_o = frame_error_q;
  assign busy_o        = (state_q != ST_HUNT);

endmodule
